// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types used by the register-read stage.
package mips_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;

    typedef logic [DATA_W-1:0]   word_t;
    typedef logic [ADDR_W-1:0]   regIdx_t;
    typedef logic [NUM_REGS-1:0] regMask_t;

    // Occupancy of the operand bundle register toward ID/EX.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } outState_t;

    function automatic regMask_t oneHot(input regIdx_t idx);
        regMask_t m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/reg_read_unit_if.sv
// Decode / write-back / ID-EX handshake bundle around the register-read stage.
interface reg_read_unit_if;
    import mips_pkg::*;

    logic    RegWrite;
    regIdx_t Rd;
    word_t   data;

    logic    ReqValid;
    regIdx_t Rs;
    regIdx_t Rt;
    regIdx_t Dest;
    logic    DestWrite;
    logic    ReqReady;

    logic    OutValid;
    logic    OutReady;
    word_t   ReadData1;
    word_t   ReadData2;
    logic    flush;

    modport master (
        output RegWrite, Rd, data,
        output ReqValid, Rs, Rt, Dest, DestWrite,
        output OutReady, flush,
        input  ReqReady, OutValid, ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, Rd, data,
        input  ReqValid, Rs, Rt, Dest, DestWrite,
        input  OutReady, flush,
        output ReqReady, OutValid, ReadData1, ReadData2
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, bit 0 never set.
module reg_scoreboard
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    setEn,
    input  regIdx_t setIdx,
    input  logic    clrEn,
    input  regIdx_t clrIdx,
    input  logic    flushEn,
    input  regIdx_t flushIdx,
    input  regIdx_t qIdxA,
    input  regIdx_t qIdxB,
    input  regIdx_t qIdxC,
    output logic    qPendA,
    output logic    qPendB,
    output logic    qPendC
);

    regMask_t pendingReg;
    regMask_t pendingNext;

    assign pendingNext[0] = 1'b0;

    // A set in the same cycle as a clear of the same register wins: the new
    // producer is younger than the write-back that is retiring.
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : gBit
            logic setHit;
            logic clrHit;
            logic flushHit;
            assign setHit   = setEn   && (setIdx   == regIdx_t'(gi));
            assign clrHit   = clrEn   && (clrIdx   == regIdx_t'(gi));
            assign flushHit = flushEn && (flushIdx == regIdx_t'(gi));
            assign pendingNext[gi] = setHit | (pendingReg[gi] & ~clrHit & ~flushHit);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendingReg <= '0;
        end else begin
            pendingReg <= pendingNext;
        end
    end

    assign qPendA = pendingReg[qIdxA];
    assign qPendB = pendingReg[qIdxB];
    assign qPendC = pendingReg[qIdxC];

endmodule

// File: rtl/reg_read_unit.sv
// Register-read stage: register mirror with write-back bypass, hazard/WAW
// stalling via the scoreboard, and a one-deep operand bundle toward ID/EX.
module reg_read_unit
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    reg_read_unit_if.slave  bus
);

    word_t     mirrorReg [NUM_REGS];
    word_t     rd1Reg;
    word_t     rd2Reg;
    regIdx_t   heldDestReg;
    outState_t outStateReg;
    outState_t outStateNext;

    logic  outValid;
    logic  accept;
    logic  pendRs;
    logic  pendRt;
    logic  pendDest;
    logic  hazRs;
    logic  hazRt;
    logic  wawStall;
    logic  slotFree;
    word_t rsVal;
    word_t rtVal;

    // Register 0 is hard-wired; the others reset asynchronously and take the write-back.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gMirror
            if (gi == 0) begin : gZero
                assign mirrorReg[gi] = '0;
            end else begin : gEntry
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        mirrorReg[gi] <= '0;
                    end else if (bus.RegWrite && (bus.Rd == regIdx_t'(gi))) begin
                        mirrorReg[gi] <= bus.data;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        rsVal = '0;
        rtVal = '0;
        if (bus.Rs != '0) begin
            rsVal = (bus.RegWrite && (bus.Rd == bus.Rs)) ? bus.data : mirrorReg[bus.Rs];
        end
        if (bus.Rt != '0) begin
            rtVal = (bus.RegWrite && (bus.Rd == bus.Rt)) ? bus.data : mirrorReg[bus.Rt];
        end
    end

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .setEn    (accept && bus.DestWrite && (bus.Dest != '0)),
        .setIdx   (bus.Dest),
        .clrEn    (bus.RegWrite),
        .clrIdx   (bus.Rd),
        .flushEn  (bus.flush && outValid),
        .flushIdx (heldDestReg),
        .qIdxA    (bus.Rs),
        .qIdxB    (bus.Rt),
        .qIdxC    (bus.Dest),
        .qPendA   (pendRs),
        .qPendB   (pendRt),
        .qPendC   (pendDest)
    );

    // A source whose producer is writing back this very cycle is satisfied by the bypass.
    assign hazRs    = pendRs && !(bus.RegWrite && (bus.Rd == bus.Rs));
    assign hazRt    = pendRt && !(bus.RegWrite && (bus.Rd == bus.Rt));
    assign wawStall = bus.DestWrite && pendDest;
    assign slotFree = !outValid || bus.OutReady;
    assign accept   = rst_n && bus.ReqValid && slotFree && !bus.flush
                      && !hazRs && !hazRt && !wawStall;

    assign outValid = (outStateReg == OUT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outStateReg <= OUT_EMPTY;
        end else begin
            outStateReg <= outStateNext;
        end
    end

    always_comb begin
        outStateNext = outStateReg;
        case (outStateReg)
            OUT_EMPTY: begin
                if (accept) begin
                    outStateNext = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (bus.flush) begin
                    outStateNext = OUT_EMPTY;
                end else if (accept) begin
                    outStateNext = OUT_FULL;
                end else if (bus.OutReady) begin
                    outStateNext = OUT_EMPTY;
                end
            end
            default: outStateNext = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1Reg      <= '0;
            rd2Reg      <= '0;
            heldDestReg <= '0;
        end else if (accept) begin
            rd1Reg      <= rsVal;
            rd2Reg      <= rtVal;
            heldDestReg <= bus.DestWrite ? bus.Dest : '0;
        end
    end

    assign bus.ReqReady  = accept;
    assign bus.OutValid  = outValid;
    assign bus.ReadData1 = rd1Reg;
    assign bus.ReadData2 = rd2Reg;

endmodule

// File: tb/tb_reg_read_unit.sv
// Directed table-driven bench for reg_read_unit plus stall, flush and reset sequences.
module tb_reg_read_unit;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nFails;

    reg_read_unit_if rrIf ();

    reg_read_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rrIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        regWrite;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        reqValid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        destWrite;
        logic        outReady;
        logic        flush;
        logic        expReady;
        logic        expValid;
        logic [31:0] expRd1;
        logic [31:0] expRd2;
    } vec_t;

    function automatic vec_t mk(
        input logic wr, input logic [4:0] rd, input logic [31:0] d,
        input logic rv, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] dest, input logic dw, input logic ordy, input logic fl,
        input logic eRdy, input logic eVal, input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.regWrite = wr;  v.rd = rd;   v.data = d;
        v.reqValid = rv;  v.rs = rs;   v.rt = rt;
        v.dest = dest;    v.destWrite = dw;
        v.outReady = ordy; v.flush = fl;
        v.expReady = eRdy; v.expValid = eVal;
        v.expRd1 = e1;    v.expRd2 = e2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rrIf.RegWrite  = v.regWrite;
        rrIf.Rd        = v.rd;
        rrIf.data      = v.data;
        rrIf.ReqValid  = v.reqValid;
        rrIf.Rs        = v.rs;
        rrIf.Rt        = v.rt;
        rrIf.Dest      = v.dest;
        rrIf.DestWrite = v.destWrite;
        rrIf.OutReady  = v.outReady;
        rrIf.flush     = v.flush;
    endtask

    task automatic applyVec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        check({tag, " ReqReady"}, {31'd0, rrIf.ReqReady}, {31'd0, v.expReady});
        @(posedge clk);
        #1;
        check({tag, " OutValid"}, {31'd0, rrIf.OutValid}, {31'd0, v.expValid});
        check({tag, " ReadData1"}, rrIf.ReadData1, v.expRd1);
        check({tag, " ReadData2"}, rrIf.ReadData2, v.expRd2);
        $display("txn %s: OutValid=%0b ReadData1=%h ReadData2=%h",
                 tag, rrIf.OutValid, rrIf.ReadData1, rrIf.ReadData2);
    endtask

    vec_t vecs [21];
    vec_t idle;
    vec_t hold;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nChecks = 0;
        nFails  = 0;

        vecs[0]  = mk(1, 8, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0, 1, 8, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 32'h0);
        vecs[2]  = mk(1, 0, 32'h1234, 1, 0, 8, 0, 0, 1, 0, 1, 1, 32'h0, 32'hDEADBEEF);
        vecs[3]  = mk(1, 3, 32'hA5A5, 1, 3, 3, 0, 0, 1, 0, 1, 1, 32'hA5A5, 32'hA5A5);
        vecs[4]  = mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hA5A5, 32'hA5A5);
        vecs[5]  = mk(0, 0, 32'h0, 1, 8, 3, 9, 1, 1, 0, 1, 1, 32'hDEADBEEF, 32'hA5A5);
        vecs[6]  = mk(0, 0, 32'h0, 1, 9, 0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 32'hA5A5);
        vecs[7]  = mk(0, 0, 32'h0, 1, 9, 0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 32'hA5A5);
        vecs[8]  = mk(1, 9, 32'h55, 1, 9, 0, 0, 0, 1, 0, 1, 1, 32'h55, 32'h0);
        vecs[9]  = mk(0, 0, 32'h0, 1, 0, 0, 12, 1, 1, 0, 1, 1, 32'h0, 32'h0);
        vecs[10] = mk(0, 0, 32'h0, 1, 1, 2, 12, 1, 1, 0, 0, 0, 32'h0, 32'h0);
        vecs[11] = mk(1, 12, 32'h7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        vecs[12] = mk(1, 13, 32'h13, 1, 12, 13, 13, 1, 1, 0, 1, 1, 32'h7, 32'h13);
        vecs[13] = mk(0, 0, 32'h0, 1, 13, 0, 0, 0, 1, 0, 0, 0, 32'h7, 32'h13);
        vecs[14] = mk(1, 13, 32'h99, 1, 13, 12, 0, 0, 1, 0, 1, 1, 32'h99, 32'h7);
        vecs[15] = mk(0, 0, 32'h0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 32'h0, 32'h0);
        vecs[16] = mk(0, 0, 32'h0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 32'h0, 32'h0);
        vecs[17] = mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        vecs[18] = mk(0, 0, 32'h0, 1, 0, 0, 14, 1, 1, 0, 1, 1, 32'h0, 32'h0);
        vecs[19] = mk(0, 0, 32'h0, 1, 0, 14, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        vecs[20] = mk(1, 14, 32'h77, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);

        // Reset with a request already present: nothing may be accepted.
        rst_n = 1'b0;
        idle  = mk(0, 0, 32'h0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        drive(idle);
        #1;
        check("reset ReqReady", {31'd0, rrIf.ReqReady}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset OutValid", {31'd0, rrIf.OutValid}, 32'h0);
        check("reset ReadData1", rrIf.ReadData1, 32'h0);
        check("reset ReadData2", rrIf.ReadData2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            applyVec(vecs[i], $sformatf("v%0d", i));
        end

        // Consumer back-pressure for three cycles, then released.
        applyVec(mk(0, 0, 32'h0, 1, 8, 3, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 32'hA5A5), "stall load");
        hold = mk(0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 32'hA5A5);
        for (int i = 0; i < 3; i++) begin
            applyVec(hold, $sformatf("stall hold%0d", i));
        end
        applyVec(mk(0, 0, 32'h0, 1, 0, 14, 0, 0, 1, 0, 1, 1, 32'h0, 32'h77), "stall release");
        applyVec(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h77), "stall drain");

        // Flush of a held bundle that owns Dest=10.
        applyVec(mk(0, 0, 32'h0, 1, 8, 0, 10, 1, 0, 0, 1, 1, 32'hDEADBEEF, 32'h0), "flush load");
        applyVec(mk(0, 0, 32'h0, 1, 10, 0, 0, 0, 1, 1, 0, 0, 32'hDEADBEEF, 32'h0), "flush");
        applyVec(mk(0, 0, 32'h0, 1, 10, 0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0), "flush reuse");
        applyVec(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0), "flush no-ready");

        // Asynchronous reset in the middle of a RAW stall on register 9.
        applyVec(mk(0, 0, 32'h0, 1, 8, 3, 9, 1, 1, 0, 1, 1, 32'hDEADBEEF, 32'hA5A5), "rst load");
        applyVec(mk(0, 0, 32'h0, 1, 9, 0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 32'hA5A5), "rst stall");
        applyVec(mk(0, 0, 32'h0, 1, 8, 3, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 32'hA5A5), "rst reload");
        @(negedge clk);
        drive(mk(0, 0, 32'h0, 1, 9, 8, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst OutValid", {31'd0, rrIf.OutValid}, 32'h0);
        check("async rst ReadData1", rrIf.ReadData1, 32'h0);
        check("async rst ReadData2", rrIf.ReadData2, 32'h0);
        check("async rst ReqReady", {31'd0, rrIf.ReqReady}, 32'h0);
        #1;
        rst_n = 1'b1;
        applyVec(mk(0, 0, 32'h0, 1, 9, 8, 0, 0, 1, 0, 1, 1, 32'h0, 32'h0), "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/reg_read_unit.md
REG_READ_UNIT -- requirements
Module: reg_read_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have port RegWrite, input, 1, write-back strobe.
REQ-004 SHALL have port Rd, input, 5, write-back destination register.
REQ-005 SHALL have port data, input, 32, write-back value.
REQ-006 SHALL have port ReqValid, input, 1, decode presents a read request.
REQ-007 SHALL have port Rs, input, 5, first source register.
REQ-008 SHALL have port Rt, input, 5, second source register.
REQ-009 SHALL have port Dest, input, 5, destination of the requesting instruction.
REQ-010 SHALL have port DestWrite, input, 1, the requesting instruction will write Dest.
REQ-011 SHALL have port ReqReady, output, 1, request accepted this cycle.
REQ-012 SHALL have port OutValid, output, 1, operand bundle valid toward ID/EX.
REQ-013 SHALL have port OutReady, input, 1, ID/EX consumes the bundle.
REQ-014 SHALL have port ReadData1, output, 32, value of Rs.
REQ-015 SHALL have port ReadData2, output, 32, value of Rt.
REQ-016 SHALL have port flush, input, 1, squash the held bundle.

Function
REQ-017 SHALL keep a 32x32 register mirror written at the clk edge when RegWrite=1 and Rd!=0; writes to register 0 SHALL be ignored.
REQ-018 SHALL always read register 0 as 32'h0.
REQ-019 SHALL keep a 32-bit pending vector; bit 0 SHALL be permanently 0.
REQ-020 SHALL define a source as hazardous when its pending bit is 1 and no write-back to that same register occurs in the current cycle.
REQ-021 SHALL assert ReqReady combinationally only when ReqValid=1, (OutValid=0 or OutReady=1), flush=0, Rs and Rt are not hazardous, and DestWrite=0 or Dest is not pending (WAW stall).
REQ-022 SHALL, on acceptance, register ReadData1 and ReadData2 and set OutValid=1 at the next edge (1-cycle latency).
REQ-023 SHALL bypass the write-back: when RegWrite=1 and Rd equals a nonzero source in the acceptance cycle, the captured value SHALL be data.
REQ-024 SHALL, on acceptance with DestWrite=1 and Dest!=0, set pending[Dest] and record Dest as the held bundle's destination.
REQ-025 SHALL clear pending[Rd] when RegWrite=1; a set and a clear of the same bit in one cycle SHALL leave the bit set.
REQ-026 SHALL hold OutValid, ReadData1 and ReadData2 stable while OutValid=1 and OutReady=0.
REQ-027 SHALL clear OutValid when OutReady=1 and there is no new acceptance.
REQ-028 SHALL, on flush=1, clear OutValid at the next edge and clear the held bundle's pending destination bit; flush SHALL take priority over OutReady.

Reset
REQ-029 SHALL, while rst_n=0, clear OutValid, ReadData1, ReadData2, the pending vector, and all 32 mirror entries to 0, independent of clk.
REQ-030 SHALL treat ReqReady as 0 during reset; a request present at deassertion SHALL be evaluated at the first clk edge after deassertion.

Structure
REQ-031 SHALL take the register-count (32), data-width (32) and address-width (5) constants from the shared package mips_pkg.
REQ-032 SHALL implement the pending vector as the sub-module reg_scoreboard (set, clear, flush-clear, query ports); the mirror and the output register SHALL remain in reg_read_unit.

Verification
REQ-033 SHALL cover: write-back $t0(8)=32'hDEADBEEF, then request Rs=8 -> ReadData1=32'hDEADBEEF, OutValid 1 cycle after ReqReady.
REQ-034 SHALL cover: request Rs=0 after RegWrite Rd=0 data=32'h1234 -> ReadData1=0.
REQ-035 SHALL cover: accept Dest=9 DestWrite=1, next request Rs=9 -> ReqReady=0 until RegWrite Rd=9 data=32'h55, then accept in that same cycle with ReadData1=32'h55.
REQ-036 SHALL cover: OutReady=0 for 3 cycles with OutValid=1 -> outputs stable, ReqReady=0; OutReady=1 -> next request accepted in that cycle.
REQ-037 SHALL cover: flush while a bundle with Dest=10 is held -> OutValid=0 next edge, pending[10]=0, request Rs=10 accepted immediately.
REQ-038 SHALL cover: rst_n low mid-stall with pending[9]=1 -> outputs and pending vector 0 asynchronously; Rs=9 accepted after deassertion.
